// File: rtl/grf_scoreboard.sv
// ============================================================================
//  Module   : grf_scoreboard
//  Purpose  : Decode-stage hazard scheduler for the 32x32 register file.
//             Tracks per-register countdowns until in-flight results become
//             forwardable, decides issue/stall, exports source countdowns
//             for the forwarding muxes and a saturating stall-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grf_scoreboard #(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [4:0]        rs,
  input  logic              rs_use,
  input  logic [CNT_W-1:0]  tuse_rs,
  input  logic [4:0]        rt,
  input  logic              rt_use,
  input  logic [CNT_W-1:0]  tuse_rt,
  input  logic [4:0]        dst,
  input  logic [CNT_W-1:0]  tnew,
  input  logic              flush,
  output logic              stall,
  output logic              issue_fire,
  output logic [CNT_W-1:0]  cnt_rs,
  output logic [CNT_W-1:0]  cnt_rt,
  output logic [31:0]       pending,
  output logic [PERF_W-1:0] stall_cycles
);

  // Countdown per architectural register; entry 0 is held at zero forever.
  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [31:0]       pending_q;
  logic [31:0]       pending_d;
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] stall_cycles_d;

  logic w_rs_haz;
  logic w_rt_haz;

  // Source countdown lookup and hazard detection against pre-update counts,
  // so an instruction's own write never stalls itself.
  always_comb begin
    cnt_rs     = (rs != 5'd0) ? cnt_q[rs] : '0;
    cnt_rt     = (rt != 5'd0) ? cnt_q[rt] : '0;
    w_rs_haz   = rs_use && (rs != 5'd0) && (cnt_rs > tuse_rs);
    w_rt_haz   = rt_use && (rt != 5'd0) && (cnt_rt > tuse_rt);
    stall      = iss_valid && (w_rs_haz || w_rt_haz);
    issue_fire = iss_valid && !stall;
  end

  assign cnt_d[0]     = '0;
  assign pending_d[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
      // Next countdown: clear beats a new write, a new write beats decrement.
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (reset || flush) begin
          cnt_d[gi] = '0;
        end else if (issue_fire && (dst == 5'(gi))) begin
          cnt_d[gi] = tnew;
        end else if (cnt_q[gi] != '0) begin
          cnt_d[gi] = cnt_q[gi] - 1'b1;
        end
        pending_d[gi] = (cnt_d[gi] != '0);
      end
    end
  endgenerate

  // Stall counter saturates at all-ones; only reset clears it.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {PERF_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      pending_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q      <= pending_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pending      = pending_q;
  assign stall_cycles = stall_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
// ============================================================================
//  Module   : tb_grf_scoreboard
//  Purpose  : Directed self-checking bench for grf_scoreboard. Stall counter
//             width is narrowed so saturation is reachable in a few cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grf_scoreboard;

  localparam int CNT_W  = 2;
  localparam int PERF_W = 4;

  logic              clk;
  logic              reset;
  logic              iss_valid;
  logic [4:0]        rs;
  logic              rs_use;
  logic [CNT_W-1:0]  tuse_rs;
  logic [4:0]        rt;
  logic              rt_use;
  logic [CNT_W-1:0]  tuse_rt;
  logic [4:0]        dst;
  logic [CNT_W-1:0]  tnew;
  logic              flush;
  logic              stall;
  logic              issue_fire;
  logic [CNT_W-1:0]  cnt_rs;
  logic [CNT_W-1:0]  cnt_rt;
  logic [31:0]       pending;
  logic [PERF_W-1:0] stall_cycles;

  int n_cmp;
  int n_err;

  grf_scoreboard #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .rs           (rs),
    .rs_use       (rs_use),
    .tuse_rs      (tuse_rs),
    .rt           (rt),
    .rt_use       (rt_use),
    .tuse_rt      (tuse_rt),
    .dst          (dst),
    .tnew         (tnew),
    .flush        (flush),
    .stall        (stall),
    .issue_fire   (issue_fire),
    .cnt_rs       (cnt_rs),
    .cnt_rt       (cnt_rt),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs settle 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; rs = 5'd0; rs_use = 1'b0; tuse_rs = '0;
    rt = 5'd0; rt_use = 1'b0; tuse_rt = '0; dst = 5'd0; tnew = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Producer only: writes dst with tnew, reads nothing.
  task automatic set_producer(input logic [4:0] d, input logic [CNT_W-1:0] n);
    idle_inputs();
    iss_valid = 1'b1; dst = d; tnew = n;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    iss_valid = 1'b1; rs = 5'd5; rs_use = 1'b1; tuse_rs = 2'd0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL reset_fire: got %b want 1", issue_fire); end
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL reset_perf: got %0d want 0", stall_cycles); end
    n_cmp++; if (cnt_rs !== 2'd0) begin n_err++; $display("FAIL reset_cnt_rs: got %0d want 0", cnt_rs); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    set_producer(5'd8, 2'd2);
    n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL raw_prod_fire: got %b want 1", issue_fire); end
    step();
    idle_inputs();
    iss_valid = 1'b1; rs = 5'd8; rs_use = 1'b1; tuse_rs = 2'd0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_stall_t1: got %b want 1", stall); end
    n_cmp++; if (cnt_rs !== 2'd2) begin n_err++; $display("FAIL raw_cnt_t1: got %0d want 2", cnt_rs); end
    n_cmp++; if (pending !== 32'h0000_0100) begin n_err++; $display("FAIL raw_pending_t1: got %h want 00000100", pending); end
    step();
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_stall_t2: got %b want 1", stall); end
    n_cmp++; if (cnt_rs !== 2'd1) begin n_err++; $display("FAIL raw_cnt_t2: got %0d want 1", cnt_rs); end
    step();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL raw_stall_t3: got %b want 0", stall); end
    n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL raw_fire_t3: got %b want 1", issue_fire); end
    n_cmp++; if (stall_cycles !== 4'd2) begin n_err++; $display("FAIL raw_perf: got %0d want 2", stall_cycles); end
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL raw_pending_t3: got %h want 0", pending); end
  endtask

  // Later consumption (tuse=1) through the rt port shortens the stall.
  task automatic test_tuse();
    do_reset();
    set_producer(5'd8, 2'd2);
    step();
    idle_inputs();
    iss_valid = 1'b1; rt = 5'd8; rt_use = 1'b1; tuse_rt = 2'd1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL tuse_stall_t1: got %b want 1", stall); end
    n_cmp++; if (cnt_rt !== 2'd2) begin n_err++; $display("FAIL tuse_cnt_rt: got %0d want 2", cnt_rt); end
    step();
    n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL tuse_fire_t2: got %b want 1", issue_fire); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL tuse_perf: got %0d want 1", stall_cycles); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_producer(5'd0, 2'd3);
    step();
    idle_inputs();
    iss_valid = 1'b1; rs = 5'd0; rs_use = 1'b1; tuse_rs = 2'd0;
    #1;
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL zero_pending: got %h want 0", pending); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall: got %b want 0", stall); end
    n_cmp++; if (cnt_rs !== 2'd0) begin n_err++; $display("FAIL zero_cnt_rs: got %0d want 0", cnt_rs); end
  endtask

  task automatic test_waw();
    do_reset();
    set_producer(5'd9, 2'd3);
    step();
    set_producer(5'd9, 2'd1);
    n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL waw_fire2: got %b want 1", issue_fire); end
    step();
    idle_inputs();
    rs = 5'd9;
    #1;
    n_cmp++; if (cnt_rs !== 2'd1) begin n_err++; $display("FAIL waw_cnt_after2: got %0d want 1", cnt_rs); end
    n_cmp++; if (pending !== 32'h0000_0200) begin n_err++; $display("FAIL waw_pending: got %h want 00000200", pending); end
    step();
    n_cmp++; if (cnt_rs !== 2'd0) begin n_err++; $display("FAIL waw_cnt_after3: got %0d want 0", cnt_rs); end
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL waw_pending3: got %h want 0", pending); end
  endtask

  // Own write ignored for hazard; new write overrides pending decrement.
  task automatic test_self_dep();
    do_reset();
    set_producer(5'd3, 2'd1);
    step();
    idle_inputs();
    iss_valid = 1'b1; rs = 5'd3; rs_use = 1'b1; tuse_rs = 2'd1; dst = 5'd3; tnew = 2'd3;
    #1;
    n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL self_fire: got %b want 1", issue_fire); end
    step();
    iss_valid = 1'b0;
    #1;
    n_cmp++; if (cnt_rs !== 2'd3) begin n_err++; $display("FAIL self_cnt: got %0d want 3", cnt_rs); end
  endtask

  task automatic test_flush();
    do_reset();
    set_producer(5'd4, 2'd3);
    flush = 1'b1;
    #1;
    n_cmp++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL flush_fire: got %b want 1", issue_fire); end
    step();
    idle_inputs();
    iss_valid = 1'b1; rs = 5'd4; rs_use = 1'b1; tuse_rs = 2'd0;
    #1;
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL flush_pending: got %h want 0", pending); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", stall); end
  endtask

  // Each pair: one producer issue (tnew=3) then three stalled consumer cycles.
  task automatic stall_pair();
    set_producer(5'd10, 2'd3);
    step();
    idle_inputs();
    iss_valid = 1'b1; rs = 5'd10; rs_use = 1'b1; tuse_rs = 2'd0;
    #1;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int p = 0; p < 4; p++) stall_pair();
    n_cmp++; if (stall_cycles !== 4'd12) begin n_err++; $display("FAIL sat_perf12: got %0d want 12", stall_cycles); end
    for (int p = 0; p < 2; p++) stall_pair();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_perf15: got %0d want 15", stall_cycles); end
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_flush_keep: got %0d want 15", stall_cycles); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_producer(5'd6, 2'd3);
    step();
    idle_inputs();
    rs = 5'd6;
    #1;
    n_cmp++; if (cnt_rs !== 2'd3) begin n_err++; $display("FAIL rmid_pre: got %0d want 3", cnt_rs); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (cnt_rs !== 2'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", cnt_rs); end
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL rmid_pending: got %h want 0", pending); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_raw_stall();
    test_tuse();
    test_zero_reg();
    test_waw();
    test_self_dep();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
